// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM state encoding,
// supported oversampling ratios and the prescale normalisation helper.
package uart_rx_pkg;

    localparam int PRESC_W = 6;
    localparam int CNT_W   = 5;

    localparam logic [PRESC_W-1:0] PRESC_8  = 6'd8;
    localparam logic [PRESC_W-1:0] PRESC_16 = 6'd16;
    localparam logic [PRESC_W-1:0] PRESC_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Only 16 and 32 are honoured; every other ratio falls back to 8.
    function automatic logic [PRESC_W-1:0] presc_norm(input logic [PRESC_W-1:0] p);
        case (p)
            PRESC_16: return PRESC_16;
            PRESC_32: return PRESC_32;
            default:  return PRESC_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote around the middle of each
// bit period. Counting only runs while the receiver is inside a frame.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               active,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] presc,
    output logic [CNT_W-1:0]   edge_cnt,
    output logic               bit_end,
    output logic               sample_done,
    output logic               sampled_bit
);

    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] cnt_ext;
    logic [2:0]         smp_q;

    assign half        = presc >> 1;
    assign cnt_ext     = {1'b0, edge_cnt};
    assign bit_end     = active && (cnt_ext == presc - 6'd1);
    // First count at which all three samples of the current bit are stored.
    assign sample_done = active && (cnt_ext == half + 6'd2);
    assign sampled_bit = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
        end else if (!active || bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q <= 3'b111;
        end else if (active) begin
            if (cnt_ext == half - 6'd1) smp_q[0] <= rx_in;
            if (cnt_ext == half)        smp_q[1] <= rx_in;
            if (cnt_ext == half + 6'd1) smp_q[2] <= rx_in;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing on an oversampled line.
// DATA_VALID, PAR_ERR and STP_ERR are single-cycle strobes with no back-pressure.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
)
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output rx_state_t             dbg_state,
    output logic [CNT_W-1:0]      dbg_edge_cnt
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    rx_state_t          state_q, state_d;
    logic [PRESC_W-1:0] presc_q;
    logic               par_en_q;
    logic               par_typ_q;
    logic [BCW-1:0]     bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic               par_bad_q;
    logic               active;
    logic               frame_start;
    logic               bit_end;
    logic               sample_done;
    logic               sampled_bit;
    logic [CNT_W-1:0]   edge_cnt;

    assign active       = (state_q != IDLE);
    assign frame_start  = (state_d == START) && (state_q != START);
    assign dbg_state    = state_q;
    assign dbg_edge_cnt = edge_cnt;

    uart_rx_sampler u_sampler (
        .clk         (CLK),
        .rst_n       (RST),
        .active      (active),
        .rx_in       (RX_IN),
        .presc       (presc_q),
        .edge_cnt    (edge_cnt),
        .bit_end     (bit_end),
        .sample_done (sample_done),
        .sampled_bit (sampled_bit)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!RX_IN) state_d = START;
            START:   if (bit_end) state_d = sampled_bit ? IDLE : DATA;
            DATA:    if (bit_end && bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            // A low line at the end of the stop bit is the next start bit.
            STOP:    if (bit_end) state_d = RX_IN ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Frame configuration is frozen for the whole frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q   <= PRESC_8;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else if (frame_start) begin
            presc_q   <= presc_norm(PRESCALE);
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt_q <= '0;
        end else if (state_q != DATA) begin
            bit_cnt_q <= '0;
        end else if (bit_end) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
        end else if (state_q == DATA && sample_done) begin
            shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        end
    end

    // Expected parity bit is ^data for even and its inverse for odd.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bad_q <= 1'b0;
        end else if (frame_start) begin
            par_bad_q <= 1'b0;
        end else if (state_q == PARITY && sample_done) begin
            par_bad_q <= sampled_bit ^ (^shift_q) ^ par_typ_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            if (state_q == STOP && bit_end) begin
                STP_ERR    <= !sampled_bit;
                PAR_ERR    <= par_bad_q;
                DATA_VALID <= sampled_bit && !par_bad_q;
                if (sampled_bit && !par_bad_q) P_DATA <= shift_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames are built bit by bit, the expected
// outcome of each is queued at issue time and a monitor checks every strobe.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int W = 8;

    logic          CLK     = 1'b0;
    logic          RST     = 1'b1;
    logic          RX_IN   = 1'b1;
    logic [5:0]    PRESCALE = 6'd8;
    logic          PAR_EN  = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [W-1:0]  P_DATA;
    logic          DATA_VALID;
    logic          PAR_ERR;
    logic          STP_ERR;
    rx_state_t     dbg_state;
    logic [4:0]    dbg_edge_cnt;

    int unsigned   cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    logic [W-1:0]  exp_q[$];
    logic [2:0]    exp_flags_q[$];
    int unsigned   exp_cyc_q[$];
    logic [W-1:0]  last_good = '0;

    uart_rx #(.DATA_WIDTH(W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .PRESCALE     (PRESCALE),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .P_DATA       (P_DATA),
        .DATA_VALID   (DATA_VALID),
        .PAR_ERR      (PAR_ERR),
        .STP_ERR      (STP_ERR),
        .dbg_state    (dbg_state),
        .dbg_edge_cnt (dbg_edge_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int eff_p(input logic [5:0] p);
        return (p == 6'd16 || p == 6'd32) ? int'(p) : 8;
    endfunction

    // Returns {data_valid, par_err, stp_err} from counting ones in the frame.
    function automatic logic [2:0] model_flags(input logic [W-1:0] d, input logic pen,
                                               input logic ptyp, input logic pbit,
                                               input logic sbit);
        int   ones;
        logic pe;
        logic se;
        ones = $countones(d) + ((pen && pbit) ? 1 : 0);
        pe   = pen && ((ones % 2) != int'(ptyp));
        se   = !sbit;
        return {!pe && !se, pe, se};
    endfunction

    function automatic logic good_parity(input logic [W-1:0] d, input logic ptyp);
        return ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ ptyp;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic [5:0] presc, input logic pen,
                              input logic ptyp, input logic pbit, input logic sbit,
                              input logic toggle);
        int         p;
        int         nbits;
        logic [2:0] fl;
        p     = eff_p(presc);
        nbits = 10 + (pen ? 1 : 0);
        fl    = model_flags(d, pen, ptyp, pbit, sbit);
        PRESCALE = presc;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        if (fl[2]) last_good = d;
        exp_flags_q.push_back(fl);
        exp_q.push_back(last_good);
        exp_cyc_q.push_back(cyc + 32'(1 + nbits * p));
        drive_bit(1'b0, p);
        for (int i = 0; i < W; i++) begin
            RX_IN = d[i];
            if (toggle && i == 2) begin
                PAR_EN   = ~pen;
                PAR_TYP  = ~ptyp;
                PRESCALE = 6'($urandom_range(0, 63));
            end
            repeat (p) @(posedge CLK);
            #1;
        end
        if (pen) drive_bit(pbit, p);
        drive_bit(sbit, p);
    endtask

    task automatic glitch(input int g, input int p);
        PRESCALE = 6'(p);
        RX_IN = 1'b0;
        repeat (g) @(posedge CLK);
        #1;
        idle(2 * p);
    endtask

    task automatic drain(input int max_cyc);
        int i;
        i = 0;
        while (exp_flags_q.size() != 0 && i < max_cyc) begin
            @(posedge CLK);
            i++;
        end
        #1;
        check("drain_pending", 32'(exp_flags_q.size()), 32'd0);
    endtask

    // Start a frame, then pull reset in the middle of data bit k.
    task automatic abort_frame(input logic [W-1:0] d, input int p, input int k);
        PRESCALE = 6'(p);
        PAR_EN   = 1'b0;
        drive_bit(1'b0, p);
        for (int i = 0; i < k; i++) drive_bit(d[i], p);
        RX_IN = d[k];
        repeat (p / 2) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("rst_p_data", 32'(P_DATA), 32'd0);
        check("rst_flags", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_edge_cnt", 32'(dbg_edge_cnt), 32'd0);
        RX_IN = 1'b1;
        last_good = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(2);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (RST && (DATA_VALID || PAR_ERR || STP_ERR)) begin
            if (exp_flags_q.size() == 0) begin
                check("unexpected_pulse", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'd0);
            end else begin
                logic [2:0]   fl;
                logic [W-1:0] dq;
                int unsigned  ec;
                fl = exp_flags_q.pop_front();
                dq = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("pulse_flags", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'(fl));
                check("pulse_p_data", 32'(P_DATA), 32'(dq));
                check("pulse_cycle", cyc, ec);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] d;
        logic [5:0]   presc;
        logic         pen;
        logic         ptyp;
        logic         pbit;
        logic         sbit;
        logic         tog;
        int           sel;
        int           gap;

        #2 RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_p_data", 32'(P_DATA), 32'd0);
        check("reset_data_valid", 32'(DATA_VALID), 32'd0);
        check("reset_par_err", 32'(PAR_ERR), 32'd0);
        check("reset_stp_err", 32'(STP_ERR), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        check("reset_edge_cnt", 32'(dbg_edge_cnt), 32'd0);
        RST = 1'b1;
        idle(2);

        // Start glitches must leave everything quiet.
        glitch(2, 8);
        check("glitch_state", 32'(dbg_state), 32'(IDLE));
        check("glitch_p_data", 32'(P_DATA), 32'd0);
        glitch(1, 16);
        check("glitch16_state", 32'(dbg_state), 32'(IDLE));

        send_frame(8'h3C, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h2B, 6'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h2B, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h55, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        send_frame(8'hA5, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h96, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(4);
        send_frame(8'hC3, 6'd13, 1'b1, 1'b1, good_parity(8'hC3, 1'b1), 1'b1, 1'b0);
        drain(200);

        abort_frame(8'hE7, 8, 3);
        send_frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drain(200);

        for (int k = 0; k < 40; k++) begin
            d   = W'($urandom);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       presc = 6'd8;
                1:       presc = 6'd16;
                2:       presc = 6'd32;
                default: presc = 6'($urandom_range(0, 63));
            endcase
            pen  = 1'($urandom_range(0, 1));
            ptyp = 1'($urandom_range(0, 1));
            pbit = good_parity(d, ptyp);
            if ($urandom_range(0, 4) == 0) pbit = ~pbit;
            sbit = ($urandom_range(0, 5) != 0);
            tog  = 1'($urandom_range(0, 1));
            send_frame(d, presc, pen, ptyp, pbit, sbit, tog);
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap);
        end
        idle(2);
        drain(500);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver that consumes the frame produced by the UART transmit path: start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit, and stop bit (1). It oversamples `RX_IN` by a configurable prescale and uses a 3-sample majority vote at mid-bit. It presents each received word on `P_DATA` with a one-cycle `DATA_VALID` pulse, and flags parity and stop errors. It sits on the RX side of the system, feeding the register file / command decoder.

## Interface
- `DATA_WIDTH`, 8, data bits per frame
- `CLK`  in  1  oversampling clock (PRESCALE × baud)
- `RST`  in  1  asynchronous, active-low reset
- `RX_IN`  in  1  serial line, idle high
- `PRESCALE`  in  6  oversampling ratio; 16 and 32 are honoured, any other value behaves as 8
- `PAR_EN`  in  1  1 = parity bit present
- `PAR_TYP`  in  1  0 = even, 1 = odd
- `P_DATA`  out  DATA_WIDTH  received word; holds its value until the next good frame
- `DATA_VALID`  out  1  one-cycle pulse when `P_DATA` is updated
- `PAR_ERR`  out  1  one-cycle pulse when the parity check fails
- `STP_ERR`  out  1  one-cycle pulse when the sampled stop bit is 0

## Operation
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Counters:** edge counter `0..PRESCALE-1` and bit counter `0..DATA_WIDTH-1`.
- **IDLE:** `RX_IN`=0 on a clock edge → START, edge counter cleared. `PRESCALE`, `PAR_EN` and `PAR_TYP` are latched at this transition. Changes to them mid-frame are ignored.
- **Sampling:** `RX_IN` is sampled at edge counts P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority and is valid from edge count P/2+2.
- **Bit end:** each bit lasts P cycles and ends at edge count P-1.
- **START:** a sampled value of 1 is a glitch → IDLE at bit end, with no outputs. A sampled value of 0 → DATA.
- **DATA:** each sample is shifted into the shift register LSB-first. After bit DATA_WIDTH-1, go to PARITY if `PAR_EN`, else STOP.
- **PARITY:** expected bit = ^data for even parity, ~^data for odd parity. A mismatch sets an internal error flag.
- **STOP, sample = 1, no parity error:** `P_DATA` ← shift register and `DATA_VALID` pulses.
- **STOP, parity error:** `PAR_ERR` pulses. `P_DATA` is unchanged and there is no `DATA_VALID`.
- **STOP, sample = 0:** `STP_ERR` pulses. There is no `DATA_VALID`, and `PAR_ERR` still pulses if applicable.
- **Leaving STOP:** at the end of the stop bit, `RX_IN`=0 goes directly to START with the edge counter at 0, so back-to-back frames lose no cycle. Otherwise go to IDLE.
- **Reset mid-frame:** aborts immediately. No pulses are produced, and the next frame is received normally.

## Timing
- **Reset values:** `P_DATA`=0, `DATA_VALID`=0, `PAR_ERR`=0, `STP_ERR`=0. FSM is in IDLE and all counters are 0.
- **Frame length:** N = 1 + DATA_WIDTH + `PAR_EN` + 1 bits.
- **Latency:** the START-entry edge is cycle 0. `DATA_VALID`, `PAR_ERR` and `STP_ERR` are registered and high only during cycle N·P, i.e. the cycle after the last edge count of the stop bit.
- **Pulse width:** exactly 1 cycle. There is no handshake; the consumer must capture on the pulse.
- **Coincident flags:** `PAR_ERR` and `STP_ERR` may coincide; `DATA_VALID` never coincides with either.
- **Minimum start width:** 1 clock to leave IDLE. Glitches shorter than P/2-1 cycles are rejected by the START check.

## Structure
- **Package `uart_rx_pkg`:**
  - state enum `rx_state_t` {IDLE, START, DATA, PARITY, STOP}
  - constants `PRESC_8`=8, `PRESC_16`=16, `PRESC_32`=32
  - function `presc_norm()` mapping illegal prescale values to 8
- **Sub-module `uart_rx_sampler`:**
  - contains the edge counter and the 3-sample majority vote
  - outputs `edge_cnt`, `bit_end`, `sample_done` and `sampled_bit`
- **Top `uart_rx`:** contains the FSM, bit counter, shift register, parity check and output registers.

## Test plan
- **Good frame, even parity:** P=8, `PAR_EN`=1, `PAR_TYP`=0, send 0x2B with parity bit 0 → at cycle 88, `P_DATA`=0x2B and `DATA_VALID`=1 for 1 cycle; no errors.
- **Parity error:** P=16, odd parity, send 0x2B with parity bit 0 → `PAR_ERR` pulse at cycle 176; `P_DATA` keeps its previous value; no `DATA_VALID`.
- **Stop error:** P=8, `PAR_EN`=0, send 0x55 with stop bit 0 → `STP_ERR` pulse at cycle 80; no `DATA_VALID`.
- **Start glitch:** P=8, `RX_IN` low for 2 cycles, then high → FSM returns to IDLE and all outputs stay 0; a following frame carrying 0x3C is received correctly.
- **Back-to-back frames:** P=32, `PAR_EN`=0, send 0xA5 then 0x3C with no idle gap → two `DATA_VALID` pulses 320 cycles apart, with the correct data on each.
- **Reset and mid-frame config change:**
  - `RST` low during DATA → outputs return to 0 immediately; the next frame is received.
  - Toggling `PAR_EN` mid-frame has no effect on the frame in progress.
